// File: rtl/ticket_pkg.sv
// rtl/ticket_pkg.sv - shared types, defaults and helpers for the ticket dispenser
package ticket_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_TYPES  = 4;
  localparam int DEF_TYPE_W     = 3;
  localparam int DEF_CNT_W      = 3;
  localparam int DEF_PULSE_HI   = 1;
  localparam int DEF_PULSE_GAP  = 1;
  localparam int DEF_STOCK_W    = 8;
  localparam int DEF_STOCK_INIT = 20;

  // Ticket codes are 1-based; code 0 and codes above the type count are invalid.
  function automatic bit code_valid(input int code, input int num);
    return (code >= 1) && (code <= num);
  endfunction

  function automatic int code_to_idx(input int code);
    return code - 1;
  endfunction

endpackage

// File: rtl/ticket_dispenser_if.sv
// rtl/ticket_dispenser_if.sv - order/refill/status bundle between control FSM and dispenser
interface ticket_dispenser_if #(
  parameter int NUM_TYPES = 4,
  parameter int TYPE_W    = 3,
  parameter int CNT_W     = 3,
  parameter int STOCK_W   = 8
);
  logic                         en;
  logic [TYPE_W-1:0]            ticket;
  logic [CNT_W-1:0]             count;
  logic                         refill;
  logic [TYPE_W-1:0]            refill_type;
  logic [NUM_TYPES-1:0]         co;
  logic                         busy;
  logic                         done;
  logic                         err;
  logic [NUM_TYPES*STOCK_W-1:0] stock_flat;

  modport master (
    output en, ticket, count, refill, refill_type,
    input  co, busy, done, err, stock_flat
  );

  modport slave (
    input  en, ticket, count, refill, refill_type,
    output co, busy, done, err, stock_flat
  );
endinterface

// File: rtl/ticket_stock.sv
// rtl/ticket_stock.sv - per-type stock counters with refill-over-decrement priority
module ticket_stock #(
  parameter int NUM_TYPES  = 4,
  parameter int TYPE_W     = 3,
  parameter int STOCK_W    = 8,
  parameter int STOCK_INIT = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_refill,
  input  logic [TYPE_W-1:0]            i_refill_idx,
  input  logic                         i_dec,
  input  logic [TYPE_W-1:0]            i_dec_idx,
  input  logic [TYPE_W-1:0]            i_sel_idx,
  output logic [STOCK_W-1:0]           o_sel_stock,
  output logic [NUM_TYPES*STOCK_W-1:0] o_stock_flat
);

  logic [STOCK_W-1:0] r_stock [NUM_TYPES];

  // Refill beats a same-cycle decrement so a refill is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TYPES; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int i = 0; i < NUM_TYPES; i++) begin
        if (i_refill && (i_refill_idx == TYPE_W'(i)))
          r_stock[i] <= STOCK_W'(STOCK_INIT);
        else if (i_dec && (i_dec_idx == TYPE_W'(i)))
          r_stock[i] <= r_stock[i] - STOCK_W'(1);
      end
    end
  end

  // Stock of the requested type, used by order validation
  always_comb begin
    o_sel_stock = '0;
    for (int i = 0; i < NUM_TYPES; i++)
      if (i_sel_idx == TYPE_W'(i)) o_sel_stock = r_stock[i];
  end

  for (genvar g = 0; g < NUM_TYPES; g++) begin : g_flat
    assign o_stock_flat[g*STOCK_W +: STOCK_W] = r_stock[g];
  end

endmodule

// File: rtl/ticket_dispenser.sv
// rtl/ticket_dispenser.sv - validates orders and issues spaced dispense pulses per ticket
module ticket_dispenser
  import ticket_pkg::*;
#(
  parameter int NUM_TYPES  = DEF_NUM_TYPES,
  parameter int TYPE_W     = DEF_TYPE_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PULSE_HI   = DEF_PULSE_HI,
  parameter int PULSE_GAP  = DEF_PULSE_GAP,
  parameter int STOCK_W    = DEF_STOCK_W,
  parameter int STOCK_INIT = DEF_STOCK_INIT
) (
  input logic               clk,
  input logic               rst,
  ticket_dispenser_if.slave bus
);

  localparam int TMR_MAX = (PULSE_HI > PULSE_GAP) ? PULSE_HI : PULSE_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t               r_state, w_state_nxt;
  logic [TMR_W-1:0]     r_tmr;
  logic [TYPE_W-1:0]    r_type, w_type_nxt;
  logic [CNT_W-1:0]     r_rem;
  logic [NUM_TYPES-1:0] r_co, w_co_nxt;
  logic                 r_busy, r_done, r_err;
  logic                 w_busy_nxt, w_done_nxt, w_err_nxt;
  logic                 w_code_ok, w_req_ok, w_accept, w_reject;
  logic                 w_tmr_last, w_dec, w_refill_ok;
  logic [TYPE_W-1:0]    w_req_idx, w_refill_idx;
  logic [STOCK_W-1:0]   w_sel_stock;

  assign w_code_ok    = code_valid(int'(bus.ticket), NUM_TYPES);
  assign w_req_idx    = TYPE_W'(code_to_idx(int'(bus.ticket)));
  assign w_req_ok     = w_code_ok && (bus.count != '0) &&
                        (w_sel_stock >= STOCK_W'(bus.count));
  assign w_accept     = (r_state == IDLE) && bus.en && w_req_ok;
  assign w_reject     = (r_state == IDLE) && bus.en && !w_req_ok;
  assign w_tmr_last   = (r_state == PULSE) ? (r_tmr == TMR_W'(PULSE_HI - 1))
                                           : (r_tmr == TMR_W'(PULSE_GAP - 1));
  assign w_dec        = (r_state == PULSE) && w_tmr_last;
  assign w_refill_ok  = bus.refill && code_valid(int'(bus.refill_type), NUM_TYPES);
  assign w_refill_idx = TYPE_W'(code_to_idx(int'(bus.refill_type)));
  assign w_type_nxt   = w_accept ? w_req_idx : r_type;

  ticket_stock #(
    .NUM_TYPES (NUM_TYPES),
    .TYPE_W    (TYPE_W),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT)
  ) u_stock (
    .clk         (clk),
    .rst         (rst),
    .i_refill    (w_refill_ok),
    .i_refill_idx(w_refill_idx),
    .i_dec       (w_dec),
    .i_dec_idx   (r_type),
    .i_sel_idx   (w_req_idx),
    .o_sel_stock (w_sel_stock),
    .o_stock_flat(bus.stock_flat)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; the last pulse of an order is the one that sees remaining==1
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = PULSE;
      PULSE: if (w_tmr_last) w_state_nxt = (r_rem == CNT_W'(1)) ? DONE : GAP;
      GAP:   if (w_tmr_last) w_state_nxt = PULSE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Order latch, remaining count and phase timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_type <= '0;
      r_rem  <= '0;
      r_tmr  <= '0;
    end else begin
      if (w_accept)   r_type <= w_req_idx;
      if (w_accept)   r_rem  <= bus.count;
      else if (w_dec) r_rem  <= r_rem - CNT_W'(1);
      if ((w_state_nxt == r_state) && ((r_state == PULSE) || (r_state == GAP)))
        r_tmr <= r_tmr + TMR_W'(1);
      else
        r_tmr <= '0;
    end
  end

  // Output values for the coming cycle, derived from the next state so outputs are registered
  always_comb begin
    for (int i = 0; i < NUM_TYPES; i++)
      w_co_nxt[i] = (w_state_nxt == PULSE) && (w_type_nxt == TYPE_W'(i));
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == DONE);
    w_err_nxt  = w_reject;
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_co   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_co   <= w_co_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign bus.co   = r_co;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_ticket_dispenser.sv
// tb/tb_ticket_dispenser.sv - directed self-checking bench for ticket_dispenser
module tb_ticket_dispenser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ticket_dispenser_if #(.NUM_TYPES(4), .TYPE_W(3), .CNT_W(3), .STOCK_W(8)) bus  ();
  ticket_dispenser_if #(.NUM_TYPES(4), .TYPE_W(3), .CNT_W(3), .STOCK_W(8)) bus6 ();

  ticket_dispenser #(
    .NUM_TYPES(4), .TYPE_W(3), .CNT_W(3), .PULSE_HI(1), .PULSE_GAP(1),
    .STOCK_W(8), .STOCK_INIT(20)
  ) u_dut (.clk(clk), .rst(rst), .bus(bus));

  ticket_dispenser #(
    .NUM_TYPES(4), .TYPE_W(3), .CNT_W(3), .PULSE_HI(2), .PULSE_GAP(3),
    .STOCK_W(8), .STOCK_INIT(20)
  ) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fld(input logic [31:0] flat, input int i);
    return flat[i*8 +: 8];
  endfunction

  // Advance one cycle and check the status outputs of one DUT
  task automatic step(input string tag, input bit d6, input logic [3:0] e_co,
                      input logic e_busy, input logic e_done, input logic e_err);
    @(negedge clk);
    if (d6) begin
      chk({tag, ".co"},   32'(bus6.co),   32'(e_co));
      chk({tag, ".busy"}, 32'(bus6.busy), 32'(e_busy));
      chk({tag, ".done"}, 32'(bus6.done), 32'(e_done));
      chk({tag, ".err"},  32'(bus6.err),  32'(e_err));
    end else begin
      chk({tag, ".co"},   32'(bus.co),   32'(e_co));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
      chk({tag, ".done"}, 32'(bus.done), 32'(e_done));
      chk({tag, ".err"},  32'(bus.err),  32'(e_err));
    end
  endtask

  // Default timing (1 high, 1 gap): pulse, gap, ..., pulse, done, idle
  task automatic ord(input string tag, input int t, input int c, input bit hold);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << (t - 1);
    n = 0;
    bus.en = 1'b1; bus.ticket = 3'(t); bus.count = 3'(c);
    for (int k = 0; k < c; k++) begin
      step(tag, 1'b0, oh, 1'b1, 1'b0, 1'b0);
      n++;
      if (n >= (hold ? 2 : 1)) bus.en = 1'b0;
      if (k != c - 1) begin
        step(tag, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        n++;
        if (n >= (hold ? 2 : 1)) bus.en = 1'b0;
      end
    end
    step(tag, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
    step(tag, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rej(input string tag, input int t, input int c);
    bus.en = 1'b1; bus.ticket = 3'(t); bus.count = 3'(c);
    step(tag, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    bus.en = 1'b0;
    step(tag, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.en = 1'b0;  bus.ticket = '0;  bus.count = '0;  bus.refill = 1'b0;  bus.refill_type = '0;
    bus6.en = 1'b0; bus6.ticket = '0; bus6.count = '0; bus6.refill = 1'b0; bus6.refill_type = '0;

    // 1. reset
    repeat (2) @(negedge clk);
    chk("rst.co",    32'(bus.co),   32'h0);
    chk("rst.busy",  32'(bus.busy), 32'h0);
    chk("rst.done",  32'(bus.done), 32'h0);
    chk("rst.err",   32'(bus.err),  32'h0);
    chk("rst.stock", bus.stock_flat, 32'h14141414);
    rst = 1'b0;
    step("idle", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // 2. basic order: type 2, two tickets
    ord("basic", 2, 2, 1'b0);
    chk("basic.stock", bus.stock_flat, 32'h14141214);

    // 3. held strobe runs one order; later strobe runs another
    ord("held", 3, 3, 1'b1);
    chk("held.stock", 32'(fld(bus.stock_flat, 2)), 32'd17);
    repeat (40) @(negedge clk);
    ord("second", 3, 3, 1'b0);
    chk("second.stock", 32'(fld(bus.stock_flat, 2)), 32'd14);

    // 4. invalid orders
    rej("inv_t0", 0, 1);
    rej("inv_t5", 5, 1);
    rej("inv_c0", 1, 0);
    chk("inv.stock", bus.stock_flat, 32'h140E1214);

    // 5. exhaustion and refill on type 1
    ord("ex1", 1, 7, 1'b0);
    chk("ex1.stock", 32'(fld(bus.stock_flat, 0)), 32'd13);
    ord("ex2", 1, 7, 1'b0);
    chk("ex2.stock", 32'(fld(bus.stock_flat, 0)), 32'd6);
    rej("ex3", 1, 7);
    chk("ex3.stock", 32'(fld(bus.stock_flat, 0)), 32'd6);
    ord("ex4", 1, 6, 1'b0);
    chk("ex4.stock", 32'(fld(bus.stock_flat, 0)), 32'd0);
    bus.refill = 1'b1; bus.refill_type = 3'd0;
    step("rf_bad0", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    bus.refill_type = 3'd5;
    step("rf_bad5", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    bus.refill = 1'b0;
    chk("rf_bad.stock", bus.stock_flat, 32'h140E1200);
    bus.refill = 1'b1; bus.refill_type = 3'd1;
    step("rf", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    bus.refill = 1'b0;
    chk("rf.stock", 32'(fld(bus.stock_flat, 0)), 32'd20);
    bus.en = 1'b1; bus.ticket = 3'd1; bus.count = 3'd2;
    step("rfdec", 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    bus.en = 1'b0; bus.refill = 1'b1; bus.refill_type = 3'd1;
    step("rfdec", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    bus.refill = 1'b0;
    chk("rfdec.stock_a", 32'(fld(bus.stock_flat, 0)), 32'd20);
    step("rfdec", 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    step("rfdec", 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
    chk("rfdec.stock_b", 32'(fld(bus.stock_flat, 0)), 32'd19);
    step("rfdec", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // 6. reset mid-order on the 2-high / 3-gap instance
    bus6.en = 1'b1; bus6.ticket = 3'd4; bus6.count = 3'd5;
    step("mid", 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);
    bus6.en = 1'b0;
    step("mid", 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);
    chk("mid.stock20", 32'(fld(bus6.stock_flat, 3)), 32'd20);
    step("mid", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("mid.stock19", 32'(fld(bus6.stock_flat, 3)), 32'd19);
    step("mid", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    step("mid", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    step("mid", 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst.co",    32'(bus6.co),   32'h0);
    chk("arst.busy",  32'(bus6.busy), 32'h0);
    chk("arst.done",  32'(bus6.done), 32'h0);
    chk("arst.stock", 32'(fld(bus6.stock_flat, 3)), 32'd20);
    @(negedge clk);
    rst = 1'b0;
    step("post", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    step("post", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    bus6.en = 1'b1; bus6.ticket = 3'd4; bus6.count = 3'd1;
    step("fresh", 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);
    bus6.en = 1'b0;
    step("fresh", 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);
    step("fresh", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
    step("fresh", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("fresh.stock", 32'(fld(bus6.stock_flat, 3)), 32'd19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
